// File: rtl/dmux4_sequencer_pkg.sv
// Shared encodings for the 1-to-4 demux driver: FSM states, slot modes and
// channel select values.
package dmux4_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_SCAN   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_e;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

endpackage

// File: rtl/dmux4_sequencer_dwell_timer.sv
// Dwell counter for the DRIVE phase of a slot: cleared by start, flags the
// last DRIVE cycle of the slot.
module dwell_timer #(
  parameter int DWELL = 12000,
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_r;

  assign done = (count_r == LAST);

  // Slot cycle counter; wraps to zero after the last cycle or on start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {CW{1'b0}};
    end else if (start || done) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/dmux4_sequencer.sv
// Break-before-make driver for a 1-to-4 demux: scans four channels from a
// pattern or drives one channel from a valid/ready load request.
module dmux4_sequencer
  import dmux4_sequencer_pkg::*;
#(
  parameter int DWELL = 12000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] pattern,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [1:0] load_chan,
  input  logic       load_data,
  output logic       s0,
  output logic       s1,
  output logic       d0,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(DWELL + 1);

  state_e     state_r, next_state_s;
  mode_e      mode_r, next_mode_s;
  logic [1:0] chan_r, next_chan_s;
  logic       bit_r, next_bit_s;
  logic       next_frame_done_s;
  logic       dwell_done_s;
  logic       start_s;

  logic [1:0] sel_r, next_sel_s;
  logic       d0_r, next_d0_s;
  logic       busy_r, next_busy_s;
  logic       frame_done_r;
  logic       load_ready_r, next_load_ready_s;

  assign start_s = (state_r == ST_SETUP);

  dwell_timer #(.DWELL(DWELL), .CW(CW)) u_dwell_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (start_s),
    .done  (dwell_done_s)
  );

  // Slot sequencing: next state, mode, channel and latched data bit.
  always_comb begin
    next_state_s      = state_r;
    next_mode_s       = mode_r;
    next_chan_s       = chan_r;
    next_bit_s        = bit_r;
    next_frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_valid) begin
          // A pending request holds off scan until it can be accepted.
          if (load_ready_r) begin
            next_mode_s  = MODE_MANUAL;
            next_chan_s  = load_chan;
            next_bit_s   = load_data;
            next_state_s = ST_SETUP;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else if (en) begin
          next_mode_s  = MODE_SCAN;
          next_chan_s  = CH0;
          next_bit_s   = pattern[0];
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        next_state_s = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (dwell_done_s) begin
          if (mode_r == MODE_MANUAL) begin
            next_state_s = ST_IDLE;
          end else if (chan_r != CH3) begin
            next_chan_s  = chan_r + 2'd1;
            next_bit_s   = pattern[next_chan_s];
            next_state_s = ST_SETUP;
          end else begin
            next_frame_done_s = 1'b1;
            if (en) begin
              next_chan_s  = CH0;
              next_bit_s   = pattern[0];
              next_state_s = ST_SETUP;
            end else begin
              next_state_s = ST_IDLE;
            end
          end
        end else begin
          next_state_s = ST_DRIVE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, decoded from the next state so the
  // pins themselves come straight from flops.
  always_comb begin
    next_sel_s        = 2'd0;
    next_d0_s         = 1'b0;
    next_busy_s       = 1'b0;
    next_load_ready_s = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        next_load_ready_s = 1'b1;
      end
      ST_SETUP: begin
        next_sel_s  = next_chan_s;
        next_busy_s = 1'b1;
      end
      ST_DRIVE: begin
        next_sel_s  = next_chan_s;
        next_d0_s   = next_bit_s;
        next_busy_s = 1'b1;
      end
      default: begin
        next_sel_s = 2'd0;
      end
    endcase
  end

  // State, latch and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_MANUAL;
      chan_r       <= CH0;
      bit_r        <= 1'b0;
      sel_r        <= 2'd0;
      d0_r         <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      load_ready_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      mode_r       <= next_mode_s;
      chan_r       <= next_chan_s;
      bit_r        <= next_bit_s;
      sel_r        <= next_sel_s;
      d0_r         <= next_d0_s;
      busy_r       <= next_busy_s;
      frame_done_r <= next_frame_done_s;
      load_ready_r <= next_load_ready_s;
    end
  end

  assign s1         = sel_r[1];
  assign s0         = sel_r[0];
  assign d0         = d0_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign load_ready = load_ready_r;

endmodule

// File: tb/tb_dmux4_sequencer.sv
// Self-checking bench for dmux4_sequencer with DWELL=4: slot-level model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_dmux4_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic       load_valid = 1'b0;
  logic [1:0] load_chan = 2'd0;
  logic       load_data = 1'b0;
  logic       load_ready, s0, s1, d0, busy, frame_done;

  int vectors = 0;
  int miscompares = 0;

  dmux4_sequencer #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .pattern    (pattern),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_chan  (load_chan),
    .load_data  (load_data),
    .s0         (s0),
    .s1         (s1),
    .d0         (d0),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Slot-level model: a slot is position 0 (setup) then positions 1..DWELL (drive).
  bit m_active, m_scan, m_bit, m_fd, m_edge;
  int m_chan, m_pos;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active <= 1'b0; m_scan <= 1'b0; m_bit <= 1'b0; m_fd <= 1'b0;
      m_edge <= 1'b0; m_chan <= 0; m_pos <= 0;
    end else begin
      m_edge <= 1'b1;
      m_fd   <= 1'b0;
      if (m_active) begin
        if (m_pos < DWELL) begin
          m_pos <= m_pos + 1;
        end else if (!m_scan) begin
          m_active <= 1'b0;
        end else if (m_chan < 3) begin
          m_chan <= m_chan + 1;
          m_pos  <= 0;
          m_bit  <= pattern[m_chan + 1];
        end else begin
          m_fd <= 1'b1;
          if (en) begin
            m_chan <= 0; m_pos <= 0; m_bit <= pattern[0];
          end else begin
            m_active <= 1'b0;
          end
        end
      end else if (load_valid) begin
        if (m_edge) begin
          m_active <= 1'b1; m_scan <= 1'b0; m_chan <= int'(load_chan);
          m_bit <= load_data; m_pos <= 0;
        end
      end else if (en) begin
        m_active <= 1'b1; m_scan <= 1'b1; m_chan <= 0; m_pos <= 0; m_bit <= pattern[0];
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rstn) begin
      chk("model_sel", int'({s1, s0}), m_active ? m_chan : 0);
      chk("model_d0", int'(d0), int'(m_active && m_pos > 0 && m_bit));
      chk("model_busy", int'(busy), int'(m_active));
      chk("model_ready", int'(load_ready), int'(m_edge && !m_active));
      chk("model_frame_done", int'(frame_done), int'(m_fd));
    end
  end

  int sel_log[1:47];
  int d0_log[1:47];
  int fd_log[1:47];

  initial begin
    int cnt;
    int first_fd;
    int second_fd;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", int'({s1, s0}), 0);
    chk("rst_d0", int'(d0), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_ready", int'(load_ready), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(load_ready), 1);

    // Manual slot on channel 2 with data 1
    load_valid = 1'b1; load_chan = 2'd2; load_data = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("man_setup_sel", int'({s1, s0}), 2);
    chk("man_setup_d0", int'(d0), 0);
    chk("man_setup_busy", int'(busy), 1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("man_drive_d0", int'(d0), 1);
      chk("man_drive_sel", int'({s1, s0}), 2);
    end
    @(negedge clk);
    chk("man_end_d0", int'(d0), 0);
    chk("man_end_sel", int'({s1, s0}), 0);
    chk("man_end_ready", int'(load_ready), 1);
    chk("man_end_busy", int'(busy), 0);

    // Manual slot on channel 1 with data 0: d0 must stay low
    load_valid = 1'b1; load_chan = 2'd1; load_data = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (d0) cnt++;
      @(negedge clk);
    end
    chk("man_zero_d0_count", cnt, 0);

    // Scan frames with pattern 1010; drop en during channel 1 DRIVE of frame 3
    pattern = 4'b1010; en = 1'b1;
    for (int i = 1; i <= 47; i++) begin
      @(negedge clk);
      sel_log[i] = int'({s1, s0});
      d0_log[i]  = int'(d0);
      fd_log[i]  = int'(frame_done);
    end
    en = 1'b0;
    chk("scan_sel_ch0", sel_log[1], 0);
    chk("scan_sel_ch1", sel_log[6], 1);
    chk("scan_sel_ch2", sel_log[11], 2);
    chk("scan_sel_ch3", sel_log[16], 3);
    chk("scan_sel_wrap", sel_log[21], 0);
    chk("scan_d0_ch0", d0_log[2], 0);
    chk("scan_d0_ch1_setup", d0_log[6], 0);
    chk("scan_d0_ch1", d0_log[7], 1);
    chk("scan_d0_ch2", d0_log[12], 0);
    chk("scan_d0_ch3_last", d0_log[20], 1);
    chk("scan_d0_wrap", d0_log[21], 0);
    cnt = 0;
    for (int i = 1; i <= 20; i++) cnt += d0_log[i];
    chk("scan_d0_ones_per_frame", cnt, 8);
    cnt = 0; first_fd = 0; second_fd = 0;
    for (int i = 1; i <= 47; i++) begin
      if (fd_log[i] != 0) begin
        cnt++;
        if (first_fd == 0) first_fd = i;
        else if (second_fd == 0) second_fd = i;
      end
    end
    chk("scan_fd_count", cnt, 2);
    chk("scan_fd_first", first_fd, 21);
    chk("scan_fd_interval", second_fd - first_fd, 20);

    // Frame completes after en drop
    cnt = 0; first_fd = 0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (frame_done) begin
        cnt++;
        first_fd = m;
      end
    end
    chk("drop_fd_count", cnt, 1);
    chk("drop_fd_pos", first_fd, 14);
    chk("drop_idle_busy", int'(busy), 0);
    chk("drop_idle_sel", int'({s1, s0}), 0);
    chk("drop_idle_ready", int'(load_ready), 1);

    // Manual beats scan; request during scan waits for frame end
    en = 1'b1; load_valid = 1'b1; load_chan = 2'd3; load_data = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("prio_man_sel", int'({s1, s0}), 3);
    chk("prio_man_busy", int'(busy), 1);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("prio_gap_busy", int'(busy), 0);
        chk("prio_gap_ready", int'(load_ready), 1);
      end
    end
    chk("prio_scan_busy", int'(busy), 1);
    chk("prio_scan_sel", int'({s1, s0}), 0);
    @(negedge clk);
    load_valid = 1'b1; load_chan = 2'd1; load_data = 1'b1; en = 1'b0;
    cnt = 0;
    for (int i = 8; i <= 26; i++) begin
      if (load_ready) cnt++;
      @(negedge clk);
    end
    chk("blocked_ready_cycles", cnt, 0);
    chk("blocked_end_fd", int'(frame_done), 1);
    chk("blocked_end_ready", int'(load_ready), 1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("blocked_accept_sel", int'({s1, s0}), 1);
    chk("blocked_accept_busy", int'(busy), 1);
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of a DRIVE with d0 high
    load_valid = 1'b1; load_chan = 2'd2; load_data = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_d0", int'(d0), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_d0", int'(d0), 0);
    chk("arst_sel", int'({s1, s0}), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(load_ready), 0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    chk("arst_no_fd", cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", int'(load_ready), 1);
    chk("arst_release_busy", int'(busy), 0);
    chk("arst_release_sel", int'({s1, s0}), 0);
    chk("arst_release_fd", int'(frame_done), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
